// File: rtl/aes_v2_sub_size_pkg.sv
// Shared lane-select and result-permutation definitions for the AES v2 SubBytes units.
// Both sub variants take their byte mappings from here so the two cannot drift apart.
package aes_v2_sub_size_pkg;

    // Bit k is set when lane k is taken from rs2 rather than rs1; lane k always uses byte k.
    localparam logic [3:0] LANE_FROM_RS2 = 4'b1010;

    // Per result byte (byte3..byte0), the index of the sbox lane placed there.
    localparam logic [7:0] PERM_PLAIN = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [7:0] PERM_ROT   = {2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] permute(input logic [31:0] lanes, input logic [7:0] perm);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[j*8 +: 8] = get_byte(lanes, perm[j*2 +: 2]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_v2_sub_size_if.sv
// Valid/ready instruction interface between the core's crypto unit and the SubBytes engine.
interface aes_v2_sub_size_if;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] rd;

    modport master (output valid, rs1, rs2, enc, rot, input  ready, rd);
    modport slave  (input  valid, rs1, rs2, enc, rot, output ready, rd);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box, forward or inverse, built around a single GF(2^8) inverter.
module aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    always_comb begin
        inv_in   = inv ? inv_affine(in_byte) : in_byte;
        inv_out  = gf_inv(inv_in);
        out_byte = inv ? inv_out : fwd_affine(inv_out);
    end

endmodule

// File: rtl/aes_v2_sub_size.sv
// Area-optimised AES v2 SubBytes/InvSubBytes: one shared sbox, one byte lane per cycle, 4-cycle latency.
// Define AES_V2_SUB_SIZE_LATCH_EN to capture operands at issue so valid may drop after the first cycle.
module aes_v2_sub_size
    import aes_v2_sub_size_pkg::*;
#(
    parameter bit CLEAR_RESULT = 1'b1
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    aes_v2_sub_size_if.slave       bus
);

    // state    | meaning
    // ST_IDLE  | waiting for valid; lane 0 computed in the issue cycle
    // ST_LANE1 | lane 1 into res[15:8]
    // ST_LANE2 | lane 2 into res[23:16]
    // ST_OUT   | lane 3 combinational, ready pulses, result assembled
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LANE1 = 2'd1;
    localparam logic [1:0] ST_LANE2 = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] res_q, res_d;
    logic [31:0] op_rs1, op_rs2;
    logic        op_enc, op_rot;
    logic [7:0]  sbox_in, sbox_out;
    logic        ready_raw, ready_o;

`ifdef AES_V2_SUB_SIZE_LATCH_EN
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic        enc_q, enc_d, rot_q, rot_d;

    // Lane 0 runs off the live inputs; later lanes use the copy taken at issue.
    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        enc_d = enc_q;
        rot_d = rot_q;
        if (cnt_q == ST_IDLE && bus.valid) begin
            rs1_d = bus.rs1;
            rs2_d = bus.rs2;
            enc_d = bus.enc;
            rot_d = bus.rot;
        end
        op_rs1 = (cnt_q == ST_IDLE) ? bus.rs1 : rs1_q;
        op_rs2 = (cnt_q == ST_IDLE) ? bus.rs2 : rs2_q;
        op_enc = (cnt_q == ST_IDLE) ? bus.enc : enc_q;
        op_rot = (cnt_q == ST_IDLE) ? bus.rot : rot_q;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rs1_q <= '0;
            rs2_q <= '0;
            enc_q <= 1'b0;
            rot_q <= 1'b0;
        end else begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            enc_q <= enc_d;
            rot_q <= rot_d;
        end
    end
`else
    assign op_rs1 = bus.rs1;
    assign op_rs2 = bus.rs2;
    assign op_enc = bus.enc;
    assign op_rot = bus.rot;
`endif

    assign sbox_in = get_byte(LANE_FROM_RS2[cnt_q] ? op_rs2 : op_rs1, cnt_q);

    aes_sbox u_sbox (
        .in_byte  (sbox_in),
        .inv      (~op_enc),
        .out_byte (sbox_out)
    );

    always_comb begin
        cnt_d     = cnt_q;
        res_d     = res_q;
        ready_raw = 1'b0;
        case (cnt_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    res_d[7:0] = sbox_out;
                    cnt_d      = ST_LANE1;
                end
            end
            ST_LANE1: begin
                res_d[15:8] = sbox_out;
                cnt_d       = ST_LANE2;
            end
            ST_LANE2: begin
                res_d[23:16] = sbox_out;
                cnt_d        = ST_OUT;
            end
            default: begin
                ready_raw = 1'b1;
                cnt_d     = ST_IDLE;
                if (CLEAR_RESULT) res_d = '0;
            end
        endcase
`ifndef AES_V2_SUB_SIZE_LATCH_EN
        // Without operand capture, losing valid mid-operation abandons it.
        if (cnt_q != ST_IDLE && !bus.valid) begin
            cnt_d     = ST_IDLE;
            res_d     = '0;
            ready_raw = 1'b0;
        end
`endif
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            cnt_q <= ST_IDLE;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign ready_o   = ready_raw & g_resetn;
    assign bus.ready = ready_o;
    assign bus.rd    = ready_o ? permute({sbox_out, res_q}, op_rot ? PERM_ROT : PERM_PLAIN) : 32'h0;

endmodule

// File: tb/tb_aes_v2_sub_size.sv
// Self-checking bench for aes_v2_sub_size against a table-driven S-box reference model.
module tb_aes_v2_sub_size;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    aes_v2_sub_size_if bus ();

    aes_v2_sub_size #(.CLEAR_RESULT(1'b1)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    always #5 g_clk = ~g_clk;

    logic [31:0] vec_rs1 [4] = '{32'h0000_0000, 32'h0053_0001, 32'h0053_0001, 32'h00ed_0063};
    logic [31:0] vec_rs2 [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h6300_0000};
    logic        vec_enc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        vec_rot [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vec_exp [4] = '{32'h6363_6363, 32'h63ed_637c, 32'hed63_7c63, 32'h0053_5200};

    // Polynomial-basis product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables;
        logic [7:0] x, inv, c, b;
        c = 8'h63;
        for (int xi = 0; xi < 256; xi++) begin
            x   = xi[7:0];
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++) if (gmul(x, yi[7:0]) == 8'h01) inv = yi[7:0];
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            fwd_tab[xi] = b;
        end
        for (int xi = 0; xi < 256; xi++) inv_tab[fwd_tab[xi]] = xi[7:0];
    endtask

    function automatic logic [31:0] model(input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic enc, input logic rot);
        logic [7:0] in_b [4];
        logic [7:0] s [4];
        in_b[0] = rs1[7:0];
        in_b[1] = rs2[15:8];
        in_b[2] = rs1[23:16];
        in_b[3] = rs2[31:24];
        for (int k = 0; k < 4; k++) s[k] = enc ? fwd_tab[in_b[k]] : inv_tab[in_b[k]];
        return rot ? {s[2], s[1], s[0], s[3]} : {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic r);
        bus.valid = v;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.enc   = e;
        bus.rot   = r;
    endtask

    task automatic next_cycle;
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 32'h1234_5678, 32'h9abc_def0, 1'b1, 1'b0);
        g_resetn = 1'b0;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge g_clk);
            checks++;
            if (bus.ready !== 1'b0 || bus.rd !== 32'h0) begin
                errors++;
                $display("FAIL reset c%0d: ready=%0b rd=%08h, want ready=0 rd=00000000", c, bus.ready, bus.rd);
            end
            next_cycle();
        end
        checks++;
        if (dut.cnt_q !== 2'd0 || dut.res_q !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d res=%06h, want 0/0", dut.cnt_q, dut.res_q);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        g_resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_vectors;
        logic exp_rdy;
        logic [31:0] exp_rd;
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, vec_rs1[v], vec_rs2[v], vec_enc[v], vec_rot[v]);
                exp_rdy = (c == 3);
                exp_rd  = (c == 3) ? vec_exp[v] : 32'h0;
                @(negedge g_clk);
                checks++;
                if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                    errors++;
                    $display("FAIL vector%0d t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                             v, c, bus.ready, bus.rd, exp_rdy, exp_rd);
                end
                next_cycle();
            end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, exp_rd;
        logic e, r, exp_rdy;
        int gap;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            e = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, a, b, e, r);
                exp_rdy = (c == 3);
                exp_rd  = (c == 3) ? model(a, b, e, r) : 32'h0;
                @(negedge g_clk);
                checks++;
                if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                    errors++;
                    $display("FAIL random op%0d t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                             n, c, bus.ready, bus.rd, exp_rdy, exp_rd);
                end
                next_cycle();
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                @(negedge g_clk);
                checks++;
                if (bus.ready !== 1'b0 || bus.rd !== 32'h0 || dut.res_q !== 24'h0) begin
                    errors++;
                    $display("FAIL random_idle op%0d: ready=%0b rd=%08h res=%06h, want 0/0/0",
                             n, bus.ready, bus.rd, dut.res_q);
                end
                next_cycle();
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic e [2];
        logic r [2];
        logic exp_rdy;
        logic [31:0] exp_rd;
        for (int k = 0; k < 2; k++) begin
            a[k] = $urandom;
            b[k] = $urandom;
            e[k] = 1'($urandom_range(0, 1));
            r[k] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, a[c/4], b[c/4], e[c/4], r[c/4]);
            exp_rdy = (c == 3 || c == 7);
            exp_rd  = exp_rdy ? model(a[c/4], b[c/4], e[c/4], r[c/4]) : 32'h0;
            @(negedge g_clk);
            checks++;
            if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                errors++;
                $display("FAIL back_to_back t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                         c, bus.ready, bus.rd, exp_rdy, exp_rd);
            end
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset_mid;
        logic [31:0] a, b, exp_rd;
        logic exp_rdy;
        a = $urandom;
        b = $urandom;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, a, b, 1'b1, 1'b0);
            if (c == 3) g_resetn = 1'b0;
            @(negedge g_clk);
            checks++;
            if (bus.ready !== 1'b0 || bus.rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid t+%0d: ready=%0b rd=%08h, want ready=0 rd=00000000", c, bus.ready, bus.rd);
            end
            next_cycle();
        end
        g_resetn = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge g_clk);
        checks++;
        if (dut.cnt_q !== 2'd0 || dut.res_q !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_state: cnt=%0d res=%06h, want 0/0", dut.cnt_q, dut.res_q);
        end
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, a, b, 1'b0, 1'b1);
            exp_rdy = (c == 3);
            exp_rd  = (c == 3) ? model(a, b, 1'b0, 1'b1) : 32'h0;
            @(negedge g_clk);
            checks++;
            if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                errors++;
                $display("FAIL after_reset t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                         c, bus.ready, bus.rd, exp_rdy, exp_rd);
            end
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_valid_drop;
        logic [31:0] a, b, exp_rd;
        logic e, r, exp_rdy;
        a = $urandom;
        b = $urandom;
        e = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        drive(1'b1, a, b, e, r);
        next_cycle();
`ifdef AES_V2_SUB_SIZE_LATCH_EN
        for (int c = 1; c < 5; c++) begin
            drive(1'b0, ~a, ~b, ~e, ~r);
            exp_rdy = (c == 3);
            exp_rd  = (c == 3) ? model(a, b, e, r) : 32'h0;
            @(negedge g_clk);
            checks++;
            if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                errors++;
                $display("FAIL valid_drop_latched t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                         c, bus.ready, bus.rd, exp_rdy, exp_rd);
            end
            next_cycle();
        end
`else
        for (int c = 1; c < 5; c++) begin
            drive(1'b0, a, b, e, r);
            @(negedge g_clk);
            checks++;
            if (bus.ready !== 1'b0 || bus.rd !== 32'h0) begin
                errors++;
                $display("FAIL valid_drop_abort t+%0d: ready=%0b rd=%08h, want ready=0 rd=00000000",
                         c, bus.ready, bus.rd);
            end
            if (c == 2) begin
                checks++;
                if (dut.cnt_q !== 2'd0 || dut.res_q !== 24'h0) begin
                    errors++;
                    $display("FAIL valid_drop_state: cnt=%0d res=%06h, want 0/0", dut.cnt_q, dut.res_q);
                end
            end
            next_cycle();
        end
`endif
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, a, b, e, r);
            exp_rdy = (c == 3);
            exp_rd  = (c == 3) ? model(a, b, e, r) : 32'h0;
            @(negedge g_clk);
            checks++;
            if (bus.ready !== exp_rdy || bus.rd !== exp_rd) begin
                errors++;
                $display("FAIL after_drop t+%0d: ready=%0b rd=%08h, want ready=%0b rd=%08h",
                         c, bus.ready, bus.rd, exp_rdy, exp_rd);
            end
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        build_tables();
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_valid_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

endmodule
